// File: rtl/video_sync_out.sv
// VGA sink: free-running raster counters drive the sync pins, and pixels are pulled
// from a vld/rdy stream only in active video once the stream's sof meets raster origin.
module video_sync_out #(
    parameter int RGB_SIZE  = 12,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sink_vld,
    output logic                sink_rdy,
    input  logic [1:0]          sink_fc,
    input  logic [RGB_SIZE-1:0] sink_rgb,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [RGB_SIZE-1:0] vga_rgb,
    output logic                locked,
    output logic                underflow,
    output logic                misalign
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_MAX  = HW'(H_DISPLAY - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_MAX  = VW'(V_DISPLAY - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic          SYNC_ON    = (SYNC_POL != 0);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          at_origin;
    logic          sof;
    logic          eol;
    logic          fc_ok;
    logic          show;
    logic          underflow_nxt;
    logic          misalign_nxt;

    // sink_fc carries {eol, sof}
    assign sof       = sink_fc[0];
    assign eol       = sink_fc[1];
    assign active    = (h_cnt <= H_ACT_MAX) && (v_cnt <= V_ACT_MAX);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign fc_ok     = (sof == at_origin) && (eol == (h_cnt == H_ACT_MAX));
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (sink_vld && sof && at_origin) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (active && (!sink_vld || !fc_ok)) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // While searching, non-sof pixels are flushed and a sof pixel is held until origin.
    always_comb begin
        sink_rdy      = 1'b0;
        show          = 1'b0;
        underflow_nxt = 1'b0;
        misalign_nxt  = 1'b0;
        if (!rst) begin
            case (state)
                SEARCH: begin
                    if (sink_vld && !sof) begin
                        sink_rdy = 1'b1;
                    end else if (sink_vld && at_origin) begin
                        sink_rdy = 1'b1;
                        show     = 1'b1;
                    end
                end
                LOCKED: begin
                    if (active) begin
                        if (!sink_vld) begin
                            sink_rdy      = 1'b1;
                            underflow_nxt = 1'b1;
                        end else if (!fc_ok) begin
                            misalign_nxt  = 1'b1;
                        end else begin
                            sink_rdy = 1'b1;
                            show     = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync <= ~SYNC_ON;
            vga_vsync <= ~SYNC_ON;
            vga_rgb   <= '0;
            underflow <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            vga_hsync <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
            vga_vsync <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
            vga_rgb   <= show ? sink_rgb : '0;
            underflow <= underflow_nxt;
            misalign  <= misalign_nxt;
        end
    end

endmodule

// File: tb/tb_video_sync_out.sv
// Randomized scoreboard bench for video_sync_out on a tiny 8x6 raster; a second
// instance with active-high sync shares the stimulus.
module tb_video_sync_out;

    localparam int RGB_SIZE = 12;
    localparam int HD = 4, HF = 1, HS = 2, HB = 1;
    localparam int VD = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic                hs0;
        logic                vs0;
        logic                hs1;
        logic                vs1;
        logic [RGB_SIZE-1:0] rgb;
        logic                lk;
        logic                un;
        logic                mis;
    } out_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                sink_vld;
    logic [1:0]          sink_fc;
    logic [RGB_SIZE-1:0] sink_rgb;
    logic                sink_rdy, vga_hsync, vga_vsync, locked, underflow, misalign;
    logic [RGB_SIZE-1:0] vga_rgb;
    logic                sink_rdy_p, vga_hsync_p, vga_vsync_p, locked_p, underflow_p, misalign_p;
    logic [RGB_SIZE-1:0] vga_rgb_p;

    int   compared   = 0;
    int   mismatched = 0;
    bit   rdy_q[$];
    out_t out_q[$];
    bit   frame_q[$];
    int   hs_total = 0;
    int   hs_mark  = 0;

    int       m_n;
    bit       m_locked;
    bit       frame_clean;
    logic [3:0] s_idx;
    logic [7:0] s_hi;
    bit       rand_hi;

    video_sync_out #(
        .RGB_SIZE(RGB_SIZE), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
    ) u_dut (
        .clk(clk), .rst(rst), .sink_vld(sink_vld), .sink_rdy(sink_rdy),
        .sink_fc(sink_fc), .sink_rgb(sink_rgb), .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync), .vga_rgb(vga_rgb), .locked(locked),
        .underflow(underflow), .misalign(misalign)
    );

    video_sync_out #(
        .RGB_SIZE(RGB_SIZE), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1)
    ) u_dut_pol1 (
        .clk(clk), .rst(rst), .sink_vld(sink_vld), .sink_rdy(sink_rdy_p),
        .sink_fc(sink_fc), .sink_rgb(sink_rgb), .vga_hsync(vga_hsync_p),
        .vga_vsync(vga_vsync_p), .vga_rgb(vga_rgb_p), .locked(locked_p),
        .underflow(underflow_p), .misalign(misalign_p)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t (raster %0d)", name, act, exp, $time, m_n);
        end
    endtask

    // Drives one cycle of source data and predicts the DUT's reaction from the raster position.
    task automatic applyStimulus(input bit r, input bit v, input bit ce, input bit cs);
        int   h, vv;
        bit   act, org, sof, eol, rdy, show, un, mis, nl;
        out_t o;
        h   = m_n % HT;
        vv  = m_n / HT;
        act = (h < HD) && (vv < VD);
        org = (m_n == 0);
        sof = (s_idx == 4'd0) ^ cs;
        eol = (s_idx[1:0] == 2'd3) ^ ce;

        rst      = r;
        sink_vld = v;
        sink_fc  = {eol, sof};
        sink_rgb = {s_hi, s_idx};

        if (org) frame_q.push_back(frame_clean);

        rdy = 0; show = 0; un = 0; mis = 0; nl = m_locked;
        if (r) begin
            nl = 0;
        end else if (!m_locked) begin
            if (v && !sof) rdy = 1;
            else if (v && org) begin rdy = 1; show = 1; nl = 1; end
        end else if (act) begin
            if (!v) begin rdy = 1; un = 1; nl = 0; end
            else if (sof != org || eol != (h == HD - 1)) begin mis = 1; nl = 0; end
            else begin rdy = 1; show = 1; end
        end

        o.hs0 = (h >= HD + HF && h < HD + HF + HS) ? 1'b0 : 1'b1;
        o.vs0 = (vv >= VD + VF && vv < VD + VF + VS) ? 1'b0 : 1'b1;
        if (r) o.hs0 = 1'b1;
        if (r) o.vs0 = 1'b1;
        o.hs1 = ~o.hs0;
        o.vs1 = ~o.vs0;
        o.rgb = show ? sink_rgb : '0;
        o.lk  = nl;
        o.un  = un;
        o.mis = mis;
        rdy_q.push_back(rdy);
        out_q.push_back(o);

        if (rdy && v) begin
            s_idx = (s_idx == 4'd11) ? 4'd0 : s_idx + 4'd1;
            if (rand_hi) s_hi = 8'($urandom_range(0, 255));
        end
        m_locked    = nl;
        m_n         = r ? 0 : (m_n + 1) % FT;
        frame_clean = org ? m_locked : (frame_clean && m_locked);
    endtask

    // Monitor: compares combinational ready this cycle and registered outputs from last cycle.
    initial begin
        bit   clean_f;
        bit   e;
        out_t o;
        forever begin
            @(negedge clk);
            if (frame_q.size() > 0) begin
                clean_f = frame_q.pop_front();
                if (clean_f) checkOutput("handshakes_per_frame", hs_total - hs_mark, HD * VD);
                hs_mark = hs_total;
            end
            if (rdy_q.size() > 0) begin
                e = rdy_q.pop_front();
                checkOutput("sink_rdy", sink_rdy, e);
                checkOutput("sink_rdy_pol1", sink_rdy_p, e);
            end
            if (sink_vld && sink_rdy_p) hs_total++;
            if (out_q.size() >= 2) begin
                o = out_q.pop_front();
                checkOutput("vga_hsync", vga_hsync, o.hs0);
                checkOutput("vga_vsync", vga_vsync, o.vs0);
                checkOutput("vga_hsync_pol1", vga_hsync_p, o.hs1);
                checkOutput("vga_vsync_pol1", vga_vsync_p, o.vs1);
                checkOutput("vga_rgb", vga_rgb, o.rgb);
                checkOutput("locked", locked, o.lk);
                checkOutput("underflow", underflow, o.un);
                checkOutput("misalign", misalign, o.mis);
            end
        end
    end

    initial begin
        bit r, v, ce, cs;
        bit arm_un, arm_mis, arm_rst;
        int h, vv;
        rst = 1'b1; sink_vld = 1'b0; sink_fc = 2'b00; sink_rgb = '0;
        m_n = 0; m_locked = 0; frame_clean = 0;
        s_idx = 4'd5; s_hi = 8'd0; rand_hi = 0;
        arm_un = 0; arm_mis = 0; arm_rst = 0;
        $display("[TB] starting video_sync_out bench");

        repeat (3) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end

        for (int c = 0; c < FT * 26; c++) begin
            @(posedge clk); #1;
            h  = m_n % HT;
            vv = m_n / HT;
            r = 0; v = (c >= FT); ce = 0; cs = 0;
            if (c == FT * 4)  arm_un  = 1;
            if (c == FT * 7)  arm_mis = 1;
            if (c == FT * 10) arm_rst = 1;
            if (arm_un && m_locked && h == 2 && vv == 1) begin v = 0; arm_un = 0; end
            if (arm_mis && m_locked && h == 1 && vv < VD) begin ce = 1; arm_mis = 0; end
            if (arm_rst && m_locked && h == 2 && vv == 2) begin r = 1; arm_rst = 0; end
            if (c >= FT * 13) begin
                rand_hi = 1;
                v  = ($urandom_range(0, 19) != 0);
                ce = ($urandom_range(0, 39) == 0);
                cs = ($urandom_range(0, 39) == 0);
                r  = ($urandom_range(0, 299) == 0);
            end
            applyStimulus(r, v, ce, cs);
        end

        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
